lif_neuron_pe: RTL and testbench

// - Parametrised leaky integrate-and-fire processing element for the spiking TPU array.
// - Each valid time-step it sums the signed weights of NUM_SYN synapses whose spike bit is 1,

---
 rtl/lif_neuron_pe.sv | 185 ++++++++++++++++++
 tb/tb_lif_neuron_pe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_pe.sv
// Leaky integrate-and-fire PE: stage 1 sums spiking synapse weights, stage 2 leaks, integrates,
// fires and runs the refractory FSM. Define LIF_SPIKE_COUNT_EN to add the saturating spike counter.
module lif_neuron_pe #(
    parameter int DATA_W     = 16,
    parameter int NUM_SYN    = 4,
    parameter int LEAK_SHIFT = 4,
    parameter int REFRAC_CYC = 2,
    parameter int COUNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [NUM_SYN-1:0]        in_spikes,
    input  logic [NUM_SYN*DATA_W-1:0] in_weights,
    input  logic [DATA_W-1:0]         threshold,
    input  logic [DATA_W-1:0]         v_reset,
    output logic                      out_valid,
    output logic                      out_spike,
    output logic [DATA_W-1:0]         membrane,
    output logic                      refractory,
`ifdef LIF_SPIKE_COUNT_EN
    output logic [COUNT_W-1:0]        spike_count,
`endif
    output logic [0:0]                dbg_state
);

    localparam int SUM_W = DATA_W + $clog2(NUM_SYN) + 1;
    localparam int ACC_W = SUM_W + 1;
    localparam int RC_W  = (REFRAC_CYC < 2) ? 1 : $clog2(REFRAC_CYC + 1);

    localparam logic [0:0] ST_INTEG  = 1'b0;
    localparam logic [0:0] ST_REFRAC = 1'b1;

    localparam logic signed [ACC_W-1:0] V_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] V_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    if (NUM_SYN < 1 || COUNT_W < 1) begin : g_param_check
        $error("lif_neuron_pe: NUM_SYN and COUNT_W must be at least 1");
    end

    // Handshake: in_valid is a one-cycle time-step strobe with no back-pressure; out_valid
    // pulses exactly two cycles later unless clear or rstn intervenes.
    logic                     s1_valid_q, s1_valid_d;
    logic signed [SUM_W-1:0]  s1_sum_q, s1_sum_d;
    logic signed [SUM_W-1:0]  syn_sum;
    logic                     out_valid_q, out_valid_d;
    logic                     out_spike_q, out_spike_d;
    logic [DATA_W-1:0]        membrane_q, membrane_d;
    logic [0:0]               state_q, state_d;
    logic [RC_W-1:0]          rcnt_q, rcnt_d;

    logic signed [DATA_W-1:0] v_cur;
    logic signed [DATA_W-1:0] leaked;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] v_next;
    logic                     fire;

    always_comb begin
        syn_sum = '0;
        for (int i = 0; i < NUM_SYN; i++) begin
            if (in_spikes[i]) begin
                syn_sum = syn_sum + SUM_W'($signed(in_weights[i*DATA_W +: DATA_W]));
            end
        end
    end

    always_comb begin
        s1_valid_d = in_valid;
        s1_sum_d   = in_valid ? syn_sum : '0;
        if (clear) begin
            s1_valid_d = 1'b0;
            s1_sum_d   = '0;
        end
    end

    // Leak on the stored membrane, then integrate in a wide accumulator and clamp.
    always_comb begin
        v_cur  = $signed(membrane_q);
        leaked = (LEAK_SHIFT == 0) ? v_cur : v_cur - (v_cur >>> LEAK_SHIFT);
        acc    = ACC_W'(leaked) + ACC_W'(s1_sum_q);
        if (acc > V_MAX) begin
            v_next = V_MAX[DATA_W-1:0];
        end else if (acc < V_MIN) begin
            v_next = V_MIN[DATA_W-1:0];
        end else begin
            v_next = acc[DATA_W-1:0];
        end
        fire = (v_next >= $signed(threshold));
    end

    always_comb begin
        out_valid_d = 1'b0;
        out_spike_d = 1'b0;
        membrane_d  = membrane_q;
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        if (s1_valid_q) begin
            out_valid_d = 1'b1;
            case (state_q)
                ST_INTEG: begin
                    if (fire) begin
                        out_spike_d = 1'b1;
                        membrane_d  = v_reset;
                        if (REFRAC_CYC > 0) begin
                            state_d = ST_REFRAC;
                            rcnt_d  = RC_W'(REFRAC_CYC);
                        end
                    end else begin
                        membrane_d = v_next;
                    end
                end
                ST_REFRAC: begin
                    rcnt_d = rcnt_q - RC_W'(1);
                    if (rcnt_q <= RC_W'(1)) begin
                        state_d = ST_INTEG;
                        rcnt_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_INTEG;
                    rcnt_d  = '0;
                end
            endcase
        end
        if (clear) begin
            out_valid_d = 1'b0;
            out_spike_d = 1'b0;
            membrane_d  = '0;
            state_d     = ST_INTEG;
            rcnt_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            out_valid_q <= 1'b0;
            out_spike_q <= 1'b0;
            membrane_q  <= '0;
            state_q     <= ST_INTEG;
            rcnt_q      <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            out_valid_q <= out_valid_d;
            out_spike_q <= out_spike_d;
            membrane_q  <= membrane_d;
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_spike  = out_spike_q;
    assign membrane   = membrane_q;
    assign refractory = (state_q == ST_REFRAC);
    assign dbg_state  = state_q;

`ifdef LIF_SPIKE_COUNT_EN
    logic [COUNT_W-1:0] spike_count_q, spike_count_d;

    always_comb begin
        spike_count_d = spike_count_q;
        if (out_spike_d && (spike_count_q != {COUNT_W{1'b1}})) begin
            spike_count_d = spike_count_q + COUNT_W'(1);
        end
        if (clear) begin
            spike_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            spike_count_q <= '0;
        end else begin
            spike_count_q <= spike_count_d;
        end
    end

    assign spike_count = spike_count_q;
`endif

endmodule

// File: tb/tb_lif_neuron_pe.sv
// Bench for lif_neuron_pe: two instances (no-leak/refractory and leak/no-refractory) share
// stimulus and are compared every cycle against a time-step reference model.
module tb_lif_neuron_pe;

    logic        clk;
    logic        rstn;
    logic        clear;
    logic        in_valid;
    logic [3:0]  in_spikes;
    logic [63:0] in_weights;
    logic [15:0] threshold;
    logic [15:0] v_reset;

    logic        ov_w   [2];
    logic        spk_w  [2];
    logic [15:0] mem_w  [2];
    logic        refr_w [2];
    logic [0:0]  st_w   [2];
    logic [15:0] sc0;
    logic [1:0]  sc1;

    lif_neuron_pe #(
        .DATA_W(16), .NUM_SYN(4), .LEAK_SHIFT(0), .REFRAC_CYC(2), .COUNT_W(16)
    ) dut0 (
        .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid),
        .in_spikes(in_spikes), .in_weights(in_weights),
        .threshold(threshold), .v_reset(v_reset),
        .out_valid(ov_w[0]), .out_spike(spk_w[0]), .membrane(mem_w[0]),
        .refractory(refr_w[0]),
`ifdef LIF_SPIKE_COUNT_EN
        .spike_count(sc0),
`endif
        .dbg_state(st_w[0])
    );

    lif_neuron_pe #(
        .DATA_W(16), .NUM_SYN(4), .LEAK_SHIFT(1), .REFRAC_CYC(0), .COUNT_W(2)
    ) dut1 (
        .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid),
        .in_spikes(in_spikes), .in_weights(in_weights),
        .threshold(threshold), .v_reset(v_reset),
        .out_valid(ov_w[1]), .out_spike(spk_w[1]), .membrane(mem_w[1]),
        .refractory(refr_w[1]),
`ifdef LIF_SPIKE_COUNT_EN
        .spike_count(sc1),
`endif
        .dbg_state(st_w[1])
    );

`ifndef LIF_SPIKE_COUNT_EN
    assign sc0 = '0;
    assign sc1 = '0;
`endif

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required normal end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        int due;
        int sum;
    } step_t;

    step_t pend_q[$];
    int    cyc;
    int    n_checks;
    int    n_errors;

    int    m_ls   [2] = '{0, 1};
    int    m_rc   [2] = '{2, 0};
    int    m_cmax [2] = '{65535, 3};
    int    mv     [2];
    int    mrefr  [2];
    int    mcnt   [2];
    int    exp_spk[2];
    int    exp_ov;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend_q.delete();
        for (int d = 0; d < 2; d++) begin
            mv[d]      = 0;
            mrefr[d]   = 0;
            mcnt[d]    = 0;
            exp_spk[d] = 0;
        end
        exp_ov = 0;
    endtask

    task automatic model_step(input int d, input int sum);
        int leaked;
        int vn;
        exp_spk[d] = 0;
        if (mrefr[d] > 0) begin
            mrefr[d]--;
        end else begin
            leaked = (m_ls[d] == 0) ? mv[d] : mv[d] - (mv[d] >>> m_ls[d]);
            vn = leaked + sum;
            if (vn > 32767)  vn = 32767;
            if (vn < -32768) vn = -32768;
            if (vn >= int'($signed(threshold))) begin
                exp_spk[d] = 1;
                mv[d]      = int'($signed(v_reset));
                mrefr[d]   = m_rc[d];
                if (mcnt[d] < m_cmax[d]) mcnt[d]++;
            end else begin
                mv[d] = vn;
            end
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d_valid", d), int'(ov_w[d]), exp_ov);
            check_eq($sformatf("d%0d_spike", d), int'(spk_w[d]), exp_spk[d]);
            check_eq($sformatf("d%0d_membrane", d), int'($signed(mem_w[d])), mv[d]);
            check_eq($sformatf("d%0d_refractory", d), int'(refr_w[d]), (mrefr[d] > 0) ? 1 : 0);
        end
`ifdef LIF_SPIKE_COUNT_EN
        check_eq("d0_count", int'(sc0), mcnt[0]);
        check_eq("d1_count", int'(sc1), mcnt[1]);
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit clr, input bit iv, input logic [3:0] sp, input logic [63:0] w);
        int s;
        clear      = clr;
        in_valid   = iv;
        in_spikes  = sp;
        in_weights = w;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            if (sp[i]) s += int'($signed(w[i*16 +: 16]));
        end
        @(posedge clk);
        #1;
        cyc++;
        if (clr) begin
            model_reset();
        end else begin
            exp_ov     = 0;
            exp_spk[0] = 0;
            exp_spk[1] = 0;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                exp_ov = 1;
                model_step(0, pend_q[0].sum);
                model_step(1, pend_q[0].sum);
                void'(pend_q.pop_front());
            end
            if (iv) pend_q.push_back('{due: cyc + 1, sum: s});
        end
        check_outputs();
        clear    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'h0, 64'h0);
    endtask

    task automatic apply_reset();
        clear    = 1'b0;
        in_valid = 1'b0;
        rstn     = 1'b0;
        #2;
        model_reset();
        check_outputs();
        @(posedge clk);
        cyc++;
        #1;
        rstn = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] w;
        logic [15:0] wi;
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        rstn       = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_spikes  = '0;
        in_weights = '0;
        threshold  = 16'd100;
        v_reset    = 16'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rstn = 1'b1;
        idle(1);

        // integrate / fire / refractory
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 4'b0011, {4{16'd30}});
        idle(3);

        // latency: single step then a continuous burst
        step(1'b1, 1'b0, 4'h0, 64'h0);
        step(1'b0, 1'b1, 4'b0001, {4{16'd10}});
        idle(4);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 4'b0101, {4{16'd7}});
        idle(3);

        // saturation, positive then negative
        threshold = 16'h7FFF;
        v_reset   = 16'h7FFF;
        step(1'b1, 1'b0, 4'h0, 64'h0);
        step(1'b0, 1'b1, 4'hF, {4{16'h7FFF}});
        idle(3);
        v_reset = 16'h0000;
        step(1'b1, 1'b0, 4'h0, 64'h0);
        step(1'b0, 1'b1, 4'hF, {4{16'h8000}});
        step(1'b0, 1'b1, 4'hF, {4{16'h8000}});
        idle(3);

        // leak on positive and negative membrane
        threshold = 16'd100;
        step(1'b1, 1'b0, 4'h0, 64'h0);
        step(1'b0, 1'b1, 4'b0001, 64'h0000_0000_0000_0040);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'h0, 64'h0);
        idle(2);
        step(1'b1, 1'b0, 4'h0, 64'h0);
        step(1'b0, 1'b1, 4'b0001, 64'h0000_0000_0000_FFC0);
        step(1'b0, 1'b1, 4'h0, 64'h0);
        idle(2);

        // async reset with a step in stage 1, then clear racing in_valid
        step(1'b0, 1'b1, 4'b0011, {4{16'd30}});
        step(1'b0, 1'b1, 4'b0011, {4{16'd30}});
        apply_reset();
        idle(3);
        step(1'b0, 1'b1, 4'b0011, {4{16'd30}});
        step(1'b1, 1'b1, 4'b0011, {4{16'd30}});
        idle(3);

        // repeated fires for the spike counter
        step(1'b1, 1'b0, 4'h0, 64'h0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 4'b0001, {4{16'd200}});
        idle(3);
        step(1'b1, 1'b0, 4'h0, 64'h0);
        idle(1);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            threshold = 16'($urandom_range(300, 50));
            if ($urandom_range(99) == 0) begin
                apply_reset();
            end else begin
                for (int i = 0; i < 4; i++) begin
                    wi = 16'(int'($urandom_range(180)) - 60);
                    w[i*16 +: 16] = wi;
                end
                step(($urandom_range(99) < 3), ($urandom_range(3) != 0),
                     4'($urandom_range(15)), w);
            end
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
